// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter sharing one exec/fin command port between NUM_REQ requesters.
// Optional ISSUE-state abort counter enabled by defining ARB_TIMEOUT_EN.
module axil_req_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 9,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_exec,
   input  logic [NUM_REQ-1:0]         req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]         req_fin,
   output logic [DATA_W-1:0]          req_rdata,
   output logic                       req_err,
   output logic                       m_exec,
   output logic                       m_we,
   output logic [ADDR_W-1:0]          m_addr,
   output logic [DATA_W-1:0]          m_wdata,
   input  logic [DATA_W-1:0]          m_rdata,
   input  logic                       m_fin,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int GW = $clog2(NUM_REQ);
   localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_t;

   state_t         state_reg;
   logic [GW-1:0]  last_grant_reg;

   logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
   logic [DATA_W-1:0] wdata_arr [NUM_REQ];
   logic [GW:0]       cand_sum  [NUM_REQ];
   logic [GW-1:0]     cand      [NUM_REQ];
   logic [NUM_REQ-1:0] hit;
   logic [GW-1:0]     winner;
   logic              any_req;

   // cand[gi] is the requester at search distance gi+1 from the last grant
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
         assign cand_sum[gi]  = {1'b0, last_grant_reg} + (GW+1)'(gi + 1);
         assign cand[gi]      = (cand_sum[gi] >= (GW+1)'(NUM_REQ))
                                ? GW'(cand_sum[gi] - (GW+1)'(NUM_REQ))
                                : cand_sum[gi][GW-1:0];
         assign hit[gi]       = req_exec[cand[gi]];
      end
   endgenerate

   always_comb begin
      winner  = '0;
      any_req = |req_exec;
      // descending scan so the nearest hit is the last one written
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (hit[k]) begin
            winner = cand[k];
         end
      end
   end

   assign busy = (state_reg != IDLE);

`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] cnt_reg;
   logic          err_reg;
   logic          timeout_hit;

   // this ISSUE cycle brings the count to TIMEOUT_CYC
   assign timeout_hit = (cnt_reg == TW'(TIMEOUT_CYC - 1));
   assign req_err     = err_reg;
`else
   assign req_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         last_grant_reg <= LAST_INIT;
         grant_id       <= '0;
         m_exec         <= 1'b0;
         m_we           <= 1'b0;
         m_addr         <= '0;
         m_wdata        <= '0;
         req_fin        <= '0;
         req_rdata      <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_reg        <= '0;
         err_reg        <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  grant_id  <= winner;
                  m_we      <= req_we[winner];
                  m_addr    <= addr_arr[winner];
                  m_wdata   <= wdata_arr[winner];
                  m_exec    <= 1'b1;
                  state_reg <= ISSUE;
`ifdef ARB_TIMEOUT_EN
                  cnt_reg   <= '0;
`endif
               end
            end
            ISSUE: begin
               if (m_fin) begin
                  m_exec <= 1'b0;
                  if (!m_we) begin
                     req_rdata <= m_rdata;
                  end
`ifdef ARB_TIMEOUT_EN
                  err_reg <= 1'b0;
`endif
                  req_fin        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
                  last_grant_reg <= grant_id;
                  state_reg      <= COMPLETE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (timeout_hit) begin
                  m_exec         <= 1'b0;
                  err_reg        <= 1'b1;
                  req_rdata      <= '0;
                  req_fin        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
                  last_grant_reg <= grant_id;
                  state_reg      <= COMPLETE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
`endif
            end
            COMPLETE: begin
               // m_we/m_addr/m_wdata held: the wrapper muxes its fin on we
               req_fin   <= '0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Randomized bench for axil_req_arbiter: requesters, a memory slave and a
// transaction-level reference model; ARB_TIMEOUT_EN selects the abort checks.
module tb_axil_req_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int AW = 9;
`ifdef ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 64;
`endif
   localparam int GW = $clog2(N);

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_exec;
   logic [N-1:0]      req_we;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N-1:0]      req_fin;
   logic [DW-1:0]     req_rdata;
   logic              req_err;
   logic              m_exec;
   logic              m_we;
   logic [AW-1:0]     m_addr;
   logic [DW-1:0]     m_wdata;
   logic [DW-1:0]     m_rdata;
   logic              m_fin;
   logic              busy;
   logic [GW-1:0]     grant_id;

   axil_req_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset),
      .req_exec(req_exec), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_fin(req_fin), .req_rdata(req_rdata), .req_err(req_err),
      .m_exec(m_exec), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_fin(m_fin), .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // requesters
   logic [N-1:0]  exec_r;
   logic          t_we    [N];
   logic [AW-1:0] t_addr  [N];
   logic [DW-1:0] t_wdata [N];
   int            mode    [N];   // 0 manual, 1 persistent, 2 random
   logic [N-1:0]  obs_fin;

   // memory slave
   logic [DW-1:0] mem [512];
   bit            s_busy;
   int            s_wait;
   bit            hang;
   bit            stray_en;
   int            s_fixdelay;

   // reference model
   int            phase;        // 0 idle, 1 issue, 2 complete
   int            last_win, cur, cnt;
   logic          cur_we;
   logic [AW-1:0] cur_addr;
   logic [DW-1:0] cur_wdata, exp_rdata;
   logic          exp_err;
   bit            granted_now;
   int            grants[$];
   int            fins;

   function automatic int rr_pick(input int last, input logic [N-1:0] v);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic set_trans(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      t_we[i] = we; t_addr[i] = a; t_wdata[i] = d;
   endtask

   task automatic drive_bus();
      req_exec = exec_r;
      for (int i = 0; i < N; i++) begin
         req_we[i]              = t_we[i];
         req_addr[i*AW +: AW]   = t_addr[i];
         req_wdata[i*DW +: DW]  = t_wdata[i];
      end
   endtask

   task automatic model_reset();
      phase = 0; last_win = N - 1; cur = 0; cnt = 0;
      cur_we = 1'b0; cur_addr = '0; cur_wdata = '0;
      exp_rdata = '0; exp_err = 1'b0; granted_now = 1'b0; obs_fin = '0;
   endtask

   task automatic model_step(input logic [N-1:0] v, input logic fin, input logic [DW-1:0] rd);
      granted_now = 1'b0;
      case (phase)
         0: if (v != 0) begin
               cur = rr_pick(last_win, v);
               cur_we = t_we[cur]; cur_addr = t_addr[cur]; cur_wdata = t_wdata[cur];
               phase = 1; cnt = 0; granted_now = 1'b1;
            end
         1: if (fin) begin
               phase = 2; exp_err = 1'b0; last_win = cur;
               if (!cur_we) exp_rdata = rd;
            end else begin
`ifdef ARB_TIMEOUT_EN
               cnt++;
               if (cnt == TO) begin
                  phase = 2; exp_err = 1'b1; exp_rdata = '0; last_win = cur;
               end
`endif
            end
         default: phase = 0;
      endcase
   endtask

   task automatic update_requesters();
      for (int i = 0; i < N; i++) begin
         if (exec_r[i] && obs_fin[i]) begin
            exec_r[i] = 1'b0;
         end else if (!exec_r[i]) begin
            if (mode[i] == 1 || (mode[i] == 2 && $urandom_range(0, 3) == 0)) begin
               set_trans(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
               exec_r[i] = 1'b1;
            end
         end else if (mode[i] == 2 && $urandom_range(0, 15) == 0) begin
            exec_r[i] = 1'b0;
         end
      end
   endtask

   task automatic update_slave();
      m_fin = 1'b0;
      if (s_busy && !m_exec) s_busy = 0;
      if (!s_busy && m_exec) begin
         s_busy = 1;
         s_wait = (s_fixdelay >= 0) ? s_fixdelay : $urandom_range(0, 3);
      end
      if (s_busy) begin
         if (s_wait == 0) begin
            if (!hang) begin
               m_fin = 1'b1;
               if (m_we) begin
                  mem[m_addr] = m_wdata;
                  m_rdata = $urandom;
               end else begin
                  m_rdata = mem[m_addr];
               end
               s_busy = 0;
            end
         end else begin
            s_wait--;
         end
      end else if (!m_exec && stray_en && $urandom_range(0, 7) == 0) begin
         m_fin   = 1'b1;
         m_rdata = $urandom;
      end
   endtask

   task automatic compare_all();
      check("busy",      busy,      phase != 0);
      check("m_exec",    m_exec,    phase == 1);
      check("req_fin",   req_fin,   (phase == 2) ? (64'd1 << cur) : 64'd0);
      check("grant_id",  grant_id,  cur);
      check("m_we",      m_we,      cur_we);
      check("m_addr",    m_addr,    cur_addr);
      check("m_wdata",   m_wdata,   cur_wdata);
      check("req_rdata", req_rdata, exp_rdata);
      check("req_err",   req_err,   exp_err);
      check("fin_onehot", $countones(req_fin) <= 1, 1);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(req_exec, m_fin, m_rdata);
      #1;
      update_requesters();
      update_slave();
      drive_bus();
      @(negedge clk);
      compare_all();
      obs_fin = req_fin;
      if (req_fin != 0) fins++;
      if (granted_now) grants.push_back(int'(grant_id));
   endtask

   task automatic wait_fin(input int budget);
      int start;
      start = fins;
      for (int c = 0; c < budget && fins == start; c++) tick();
      check("fin_wait", fins != start, 1);
   endtask

   task automatic drain();
      for (int c = 0; c < 200 && !(phase == 0 && exec_r == 0); c++) tick();
      check("drain", phase == 0 && exec_r == 0, 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exec_r = '0; m_fin = 1'b0; s_busy = 0; hang = 0;
      drive_bus();
      #1;
      check("rst_m_exec",  m_exec,    0);
      check("rst_req_fin", req_fin,   0);
      check("rst_busy",    busy,      0);
      check("rst_grant",   grant_id,  0);
      check("rst_rdata",   req_rdata, 0);
      check("rst_m_addr",  m_addr,    0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      int start;
      reset = 1'b1;
      m_fin = 1'b0; m_rdata = '0; s_busy = 0; s_wait = 0; hang = 0;
      stray_en = 0; s_fixdelay = -1; fins = 0;
      for (int i = 0; i < N; i++) begin mode[i] = 0; set_trans(i, 1'b0, '0, '0); end
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      do_reset();

      // single write from requester 0
      set_trans(0, 1'b1, 9'h10, 32'hDEADBEEF); exec_r[0] = 1'b1; drive_bus();
      tick();
      check("wr_m_exec", m_exec, 1);
      check("wr_m_addr", m_addr, 9'h10);
      check("wr_m_wdata", m_wdata, 32'hDEADBEEF);
      wait_fin(20);
      check("wr_fin0", obs_fin, 3'b001);
      tick();
      check("wr_busy_fall", busy, 0);
      check("wr_mem", mem[9'h10], 32'hDEADBEEF);

      // single read from requester 1
      set_trans(1, 1'b0, 9'h10, '0); exec_r[1] = 1'b1; drive_bus();
      wait_fin(20);
      check("rd_fin1", obs_fin, 3'b010);
      check("rd_data", req_rdata, 32'hDEADBEEF);
      check("rd_err", req_err, 0);
      drain();

      // contention from reset, persistent requesters 0 and 1
      do_reset();
      grants.delete();
      mode[0] = 1; mode[1] = 1;
      set_trans(0, 1'b0, 9'h3, '0); set_trans(1, 1'b1, 9'h4, 32'h1234);
      exec_r[0] = 1'b1; exec_r[1] = 1'b1; drive_bus();
      repeat (4) wait_fin(20);
      mode[0] = 0; mode[1] = 0;
      drain();
      check("cont_count", grants.size() >= 4, 1);
      for (int k = 0; k < grants.size() && k < 4; k++) check($sformatf("cont_g%0d", k), grants[k], k % 2);

      // late arrival during ISSUE
      grants.delete();
      s_fixdelay = 4;
      set_trans(0, 1'b1, 9'h20, 32'hA5A5A5A5); exec_r[0] = 1'b1; drive_bus();
      tick(); tick();
      set_trans(1, 1'b0, 9'h20, '0); exec_r[1] = 1'b1; drive_bus();
      repeat (2) wait_fin(20);
      check("late_count", grants.size(), 2);
      for (int k = 0; k < grants.size() && k < 2; k++) check($sformatf("late_g%0d", k), grants[k], k);
      check("late_rdata", req_rdata, 32'hA5A5A5A5);
      drain();
      s_fixdelay = -1;

      // reset three cycles into a read
      hang = 1;
      set_trans(2, 1'b0, 9'h7, '0); exec_r[2] = 1'b1; drive_bus();
      repeat (4) tick();
      check("mid_busy", busy, 1);
      do_reset();
      grants.delete();
      set_trans(0, 1'b0, 9'h1, '0); set_trans(1, 1'b0, 9'h2, '0);
      exec_r[0] = 1'b1; exec_r[1] = 1'b1; drive_bus();
      tick();
      check("post_rst_grant", grant_id, 0);
      drain();

      // slave never completes
      hang = 1;
      set_trans(1, 1'b0, 9'h5, '0); exec_r[1] = 1'b1; drive_bus();
`ifdef ARB_TIMEOUT_EN
      wait_fin(TO + 5);
      check("to_fin1", obs_fin, 3'b010);
      check("to_err", req_err, 1);
      check("to_rdata", req_rdata, 0);
      hang = 0;
      drain();
`else
      repeat (200) tick();
      check("hang_busy", busy, 1);
      check("hang_m_exec", m_exec, 1);
      do_reset();
`endif

      // random traffic with stray m_fin pulses
      start = fins;
      stray_en = 1;
      for (int i = 0; i < N; i++) mode[i] = 2;
      repeat (2000) tick();
      for (int i = 0; i < N; i++) mode[i] = 0;
      stray_en = 0;
      drain();
      check("rand_progress", fins > start + 50, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
